// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: widths, reset constants,
// fetch FSM encodings and the fetch packet carried into the IF/ID register.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM encodings
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_DROP = 2'd2;
  localparam fetch_state_t S_BUF  = 2'd3;

  // Instruction plus the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Sequential PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; a consumed entry
// with nothing new behind it becomes a bubble.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  fetch_pkt_t      pkt_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  // Next-state selection for the pipeline register
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = pkt_i.inst;
      pc_d    = pkt_i.pc;
      pc4_d   = pc_plus4(pkt_i.pc);
    end else if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with NOP reset contents
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP;
      pc_q    <= '0;
      pc4_q   <= XLEN'(4);
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o    = valid_q;
  assign inst_o     = inst_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch: PC generation, single-outstanding imem handshake,
// one-entry skid buffer for stalled responses, redirect handling, and the
// IF/ID register feeding decode.
module fetch_if_id
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP      = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  fetch_pkt_t      buf_q, buf_d;

  logic       req_hs_c;
  logic       accept_c;
  logic       load_c;
  fetch_pkt_t resp_pkt_c;
  fetch_pkt_t load_pkt_c;

  // Request is only offered from S_REQ and never while in reset
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign req_hs_c       = imem_req_valid && imem_req_ready;
  assign accept_c       = !id_valid || !stall;
  assign resp_pkt_c     = '{inst: imem_resp_data, pc: req_pc_q};

  // Fetch FSM next-state, PC update and IF/ID load selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    buf_d      = buf_q;
    load_c     = 1'b0;
    load_pkt_c = resp_pkt_c;
    case (state_q)
      S_REQ: begin
        if (req_hs_c) begin
          req_pc_d = pc_q;
          pc_d     = pc_plus4(pc_q);
          state_d  = S_WAIT;
        end
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_hs_c) state_d = S_DROP;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          if (accept_c) begin
            load_c  = 1'b1;
            state_d = S_REQ;
          end else begin
            buf_d   = resp_pkt_c;
            state_d = S_BUF;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp_valid) state_d = S_REQ;
      end
      S_BUF: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          load_c     = 1'b1;
          load_pkt_c = buf_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Fetch state, PC and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      buf_q    <= buf_d;
    end
  end

  if_id_reg #(
    .NOP(NOP)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_c),
    .flush_i    (redirect_valid),
    .stall_i    (stall),
    .pkt_i      (load_pkt_c),
    .valid_o    (id_valid),
    .inst_o     (id_inst),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: per-cycle vector table for streaming, stall,
// redirect and ready-low behaviour, then hand sequences for S_DROP,
// mid-transaction reset and PC wrap.
module tb_fetch_if_id;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_if_id dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
  );

  always #5 clk = ~clk;

  // imem model: responds addr|0x13 exactly lat cycles after a handshake
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic        hs_q = 1'b0;
  logic [31:0] hs_addr_q = 32'h0;

  always @(posedge clk) begin
    hs_q      <= imem_req_valid && imem_req_ready;
    hs_addr_q <= imem_req_addr;
  end

  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    if (hs_q) begin
      cnt   = lat;
      paddr = hs_addr_q;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = paddr | 32'h13;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Wait (bounded) for id_valid after a posedge; a timeout counts as a failure
  task automatic wait_id(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: id_valid never rose within 16 cycles", name);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        stl;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic s, input logic r, input logic [31:0] rp,
                              input logic rv, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t t;
    t.ready = rdy; t.stl = s; t.redir = r; t.rpc = rp;
    t.e_rv = rv; t.e_addr = a; t.e_v = v; t.e_pc = p; t.e_inst = ins;
    return t;
  endfunction

  vec_t vecs[24];

  initial begin
    // streaming, 1-cycle latency
    vecs[0]  = mk(1, 0, 0, 0,     0, 32'h04,  0, 32'h00,  32'h13);
    vecs[1]  = mk(1, 0, 0, 0,     1, 32'h04,  1, 32'h00,  32'h13);
    vecs[2]  = mk(1, 0, 0, 0,     0, 32'h08,  0, 32'h00,  32'h13);
    vecs[3]  = mk(1, 0, 0, 0,     1, 32'h08,  1, 32'h04,  32'h17);
    vecs[4]  = mk(1, 0, 0, 0,     0, 32'h0C,  0, 32'h04,  32'h17);
    vecs[5]  = mk(1, 0, 0, 0,     1, 32'h0C,  1, 32'h08,  32'h1B);
    // stall for 5 cycles: response lands in the buffer
    vecs[6]  = mk(1, 1, 0, 0,     0, 32'h10,  1, 32'h08,  32'h1B);
    vecs[7]  = mk(1, 1, 0, 0,     0, 32'h10,  1, 32'h08,  32'h1B);
    vecs[8]  = mk(1, 1, 0, 0,     0, 32'h10,  1, 32'h08,  32'h1B);
    vecs[9]  = mk(1, 1, 0, 0,     0, 32'h10,  1, 32'h08,  32'h1B);
    vecs[10] = mk(1, 1, 0, 0,     0, 32'h10,  1, 32'h08,  32'h1B);
    vecs[11] = mk(1, 0, 0, 0,     1, 32'h10,  1, 32'h0C,  32'h1F);
    vecs[12] = mk(1, 0, 0, 0,     0, 32'h14,  0, 32'h0C,  32'h1F);
    vecs[13] = mk(1, 0, 0, 0,     1, 32'h14,  1, 32'h10,  32'h13);
    vecs[14] = mk(1, 0, 0, 0,     0, 32'h18,  0, 32'h10,  32'h13);
    // redirect coincident with the response
    vecs[15] = mk(1, 0, 1, 32'h100, 1, 32'h100, 0, 32'h10,  32'h13);
    vecs[16] = mk(1, 0, 0, 0,     0, 32'h104, 0, 32'h10,  32'h13);
    vecs[17] = mk(1, 0, 0, 0,     1, 32'h104, 1, 32'h100, 32'h113);
    // ready low for 4 cycles, redirect inside the window
    vecs[18] = mk(0, 0, 0, 0,     1, 32'h104, 0, 32'h100, 32'h113);
    vecs[19] = mk(0, 0, 0, 0,     1, 32'h104, 0, 32'h100, 32'h113);
    vecs[20] = mk(0, 0, 1, 32'h180, 1, 32'h180, 0, 32'h100, 32'h13);
    vecs[21] = mk(0, 0, 0, 0,     1, 32'h180, 0, 32'h100, 32'h13);
    vecs[22] = mk(1, 0, 0, 0,     0, 32'h184, 0, 32'h100, 32'h13);
    vecs[23] = mk(1, 0, 0, 0,     1, 32'h184, 1, 32'h180, 32'h193);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_valid",  32'(id_valid),       32'h0);
    chk("rst_id_inst",   id_inst,             32'h13);
    chk("rst_id_pc",     id_pc,               32'h0);
    chk("rst_id_pc4",    id_pc_plus4,         32'h4);
    chk("rst_req_addr",  imem_req_addr,       32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);

    // table-driven per-cycle vectors
    for (int i = 0; i < 24; i++) begin
      imem_req_ready = vecs[i].ready;
      stall          = vecs[i].stl;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_req_addr", i),  imem_req_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d_id_valid", i),  32'(id_valid),       32'(vecs[i].e_v));
      chk($sformatf("v%0d_id_pc", i),     id_pc,               vecs[i].e_pc);
      chk($sformatf("v%0d_id_inst", i),   id_inst,             vecs[i].e_inst);
      chk($sformatf("v%0d_id_pc4", i),    id_pc_plus4,         vecs[i].e_pc + 32'h4);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;

    // redirect while waiting on a 3-cycle response -> late response dropped
    lat = 3;
    @(posedge clk); #1;
    chk("drop_hs_addr", imem_req_addr, 32'h188);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(posedge clk); #1;
    chk("drop_req_valid", 32'(imem_req_valid), 32'h0);
    chk("drop_addr",      imem_req_addr,       32'h200);
    chk("drop_id_valid",  32'(id_valid),       32'h0);
    chk("drop_id_inst",   id_inst,             32'h13);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_wait_req_valid", 32'(imem_req_valid), 32'h0);
    @(posedge clk); #1;
    chk("drop_done_req_valid", 32'(imem_req_valid), 32'h1);
    chk("drop_done_addr",      imem_req_addr,       32'h200);
    chk("drop_done_id_valid",  32'(id_valid),       32'h0);
    wait_id("drop_first");
    chk("drop_first_pc",   id_pc,       32'h200);
    chk("drop_first_inst", id_inst,     32'h213);
    chk("drop_first_pc4",  id_pc_plus4, 32'h204);
    @(negedge clk);

    // reset asserted while a request is in flight
    @(posedge clk); #1;
    chk("mid_hs_addr", imem_req_addr, 32'h208);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mid_rst_id_valid",  32'(id_valid),       32'h0);
    chk("mid_rst_id_inst",   id_inst,             32'h13);
    chk("mid_rst_id_pc",     id_pc,               32'h0);
    chk("mid_rst_id_pc4",    id_pc_plus4,         32'h4);
    chk("mid_rst_addr",      imem_req_addr,       32'h0);
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("late_resp_id_valid", 32'(id_valid),       32'h0);
    chk("late_resp_id_inst",  id_inst,             32'h13);
    chk("late_resp_req",      32'(imem_req_valid), 32'h1);
    chk("late_resp_addr",     imem_req_addr,       32'h0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hs_addr", imem_req_addr, 32'h4);
    wait_id("post_rst_first");
    chk("post_rst_first_pc",   id_pc,   32'h0);
    chk("post_rst_first_inst", id_inst, 32'h13);
    lat = 1;
    @(negedge clk);

    // PC wrap from FFFF_FFFC
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    chk("wrap_redir_addr",  imem_req_addr,       32'hFFFF_FFFC);
    chk("wrap_redir_valid", 32'(imem_req_valid), 32'h1);
    chk("wrap_flush",       32'(id_valid),       32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap_id_valid", 32'(id_valid), 32'h1);
    chk("wrap_id_pc",    id_pc,         32'hFFFF_FFFC);
    chk("wrap_id_inst",  id_inst,       32'hFFFF_FFFF);
    chk("wrap_id_pc4",   id_pc_plus4,   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Generates the PC, runs a single-outstanding-request handshake to instruction memory, and presents id_inst/id_pc to decode.
- Decode, the immediate generator and control decode consume id_inst directly.
- Handles hazard-unit stalls and EX-stage branch/jump redirects (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, ADDI x0,x0,0 placed in id_inst on reset/flush.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_resp_valid  in  1  instruction returned, 1-cycle pulse, in order, latency >=1.
- imem_resp_data  in  32  returned instruction.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect_valid  in  1  EX taken branch/jump.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  IF/ID holds a live instruction.
- id_inst  out  32  instruction to decode/immediate generator.
- id_pc  out  32  PC of id_inst.
- id_pc_plus4  out  32  id_pc+4 (JAL/JALR link).

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=S_REQ, buffer empty.
  - id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=4.
  - imem_req_valid forced 0 while rst=1.
  - Reset mid-transaction abandons it; a late response is ignored because state is S_REQ.
- Only one request is outstanding at a time. imem_req_addr=pc; pc increments by 4 (mod 2^32, wraps at FFFF_FFFC→0).
- IF/ID load rule: accept when (!id_valid || !stall). When IF/ID is consumed (id_valid && !stall) and nothing loads, id_valid<=0 (bubble).
- States:
  - S_REQ: imem_req_valid=1.
    - Handshake (valid&&ready): req_pc<=pc, pc<=pc+4, go S_WAIT.
    - Redirect without handshake: pc<=redirect_pc, stay.
    - Redirect with handshake: pc<=redirect_pc, go S_DROP.
  - S_WAIT: imem_req_valid=0.
    - resp && redirect: discard, pc<=redirect_pc, go S_REQ.
    - resp, IF/ID accepts: id_inst<=data, id_pc<=req_pc, id_valid<=1, go S_REQ.
    - resp, IF/ID cannot accept: buf<=data, buf_pc<=req_pc, go S_BUF.
    - Redirect without resp: pc<=redirect_pc, go S_DROP.
  - S_DROP: imem_req_valid=0.
    - resp: discard, go S_REQ.
    - Further redirect: update pc, stay.
  - S_BUF: imem_req_valid=0.
    - Redirect: drop buffer, pc<=redirect_pc, go S_REQ.
    - Else when !stall: IF/ID<=buffer, id_valid=1, go S_REQ.
- Redirect flush: the same edge sets id_valid<=0 and id_inst<=NOP_INST, regardless of stall. Redirect overrides every other load.
- Stall with id_valid=1: id_* outputs bit-stable.
- Throughput: 1 instr / 2 cycles at 1-cycle imem latency. The gap between loads is (latency + 1) cycles.
- id_pc_plus4 is registered alongside id_pc.
- No misalignment checking; redirect_pc[1:0] is passed through unchanged.

Decomposition:
- Shared package core_pkg: NOP_INST, RESET_PC default, XLEN=32, fetch-state enum {S_REQ,S_WAIT,S_DROP,S_BUF}.
- One sub-module, if_id_reg: the IF/ID register with load/flush/hold controls and NOP reset. The FSM, PC and buffer stay in fetch_if_id.

Test Plan:
- Reset, then 1-cycle imem, ready=1, memory[addr]=addr|0x13 → requests at 0,4,8; id_pc 0,4,8 with matching id_inst; id_valid high every 2nd cycle; id_pc_plus4=id_pc+4.
- stall=1 for 5 cycles while a response arrives → S_BUF entered, no new request, id_* stable. On stall release the buffered instr loads next edge and fetch resumes at the next PC.
- redirect_valid with redirect_pc=0x100 in the same cycle as imem_resp_valid → response discarded, id_valid=0, id_inst=0x13, next imem_req_addr=0x100.
- Redirect to 0x200 while in S_WAIT (3-cycle latency) → S_DROP, late response discarded, next request addr 0x200, first id_pc=0x200.
- imem_req_ready low for 4 cycles → imem_req_valid and addr held constant, pc unchanged; a redirect during this window replaces the address with no extra request.
- Assert rst while in S_WAIT → outputs return to reset values, the in-flight response is ignored, and the first request after reset uses RESET_PC.
